// File: rtl/bcd_dd_sequencer.sv
// Multi-cycle binary-to-BCD converter (double dabble) behind a start/done handshake.
// One add-3 correction cell per BCD digit; the FSM alternates correct and shift.

module bcd_dd_add3 (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);
    // Codes 10..15 never reach this cell for legal operands; they simply wrap.
    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for start; results held
// ADJUST | add-3 correction applied to every digit of sh_bcd
// SHIFT  | {sh_bcd, sh_bin} shifted left one bit; finishes after BIN_W shifts
module bcd_dd_sequencer #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int WIDE_W = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   sh_bin;
    logic [BCD_W-1:0]   sh_bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_acc;

    logic [BCD_W-1:0]   adj_bcd;
    logic [WIDE_W-1:0]  shifted;
    logic               out_bit;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_dd_add3 u_cell (
            .d_in  (sh_bcd[4*k +: 4]),
            .d_out (adj_bcd[4*k +: 4])
        );
    end

    // Concatenated shift keeps BIN_W=1 and DIGITS=1 free of degenerate slices.
    always_comb begin
        shifted = {sh_bcd, sh_bin} << 1;
        out_bit = sh_bcd[BCD_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh_bin   <= '0;
            sh_bcd   <= '0;
            bit_cnt  <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_bin  <= bin;
                        sh_bcd  <= '0;
                        ovf_acc <= 1'b0;
                        bit_cnt <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= ADJUST;
                    end
                end
                ADJUST: begin
                    sh_bcd <= adj_bcd;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    sh_bcd  <= shifted[WIDE_W-1:BIN_W];
                    sh_bin  <= shifted[BIN_W-1:0];
                    ovf_acc <= ovf_acc | out_bit;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        bcd      <= shifted[WIDE_W-1:BIN_W];
                        overflow <= ovf_acc | out_bit;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= ADJUST;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_dd_sequencer.sv
// Bench for bcd_dd_sequencer: a 3-digit and a 2-digit instance checked against
// an arithmetic decimal model.
module tb_bcd_dd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        busy, done, overflow;
    logic        busy2, done2, overflow2;
    logic [11:0] bcd;
    logic [7:0]  bcd2;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_sel = 0;

    logic        o_busy, o_done, o_ovf;
    logic [11:0] o_bcd;
    assign o_busy = (cur_sel != 0) ? busy2 : busy;
    assign o_done = (cur_sel != 0) ? done2 : done;
    assign o_ovf  = (cur_sel != 0) ? overflow2 : overflow;
    assign o_bcd  = (cur_sel != 0) ? {4'h0, bcd2} : bcd;

    always #5 clk = ~clk;

    bcd_dd_sequencer #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bcd_dd_sequencer #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
    );

    function automatic int pow10(input int digits);
        int m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        return m;
    endfunction

    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] res = '0;
        int r = v % pow10(digits);
        for (int i = 0; i < digits; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input int v, input int digits);
        return v >= pow10(digits);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic s, input logic [7:0] b);
        if (sel != 0) begin
            start2 = s; bin2 = b;
        end else begin
            start = s; bin = b;
        end
    endtask

    task automatic run_conv(input int sel, input int v, input string name);
        logic [11:0] exp_b, prev;
        logic        exp_o;
        int          lat, digits;
        bit          held;
        cur_sel = sel;
        digits  = (sel != 0) ? 2 : 3;
        exp_b   = ref_bcd(v, digits);
        exp_o   = ref_ovf(v, digits);
        #0;
        prev    = o_bcd;
        set_in(sel, 1'b1, 8'(v));
        tick;
        set_in(sel, 1'b0, 8'($urandom));
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_accept: got %b want 1", name, o_busy);
        end
        lat = 0; held = 1;
        while (lat < 40) begin
            tick; lat++;
            if (o_done === 1'b1) break;
            if (o_bcd !== prev) held = 0;
        end
        n_tests++;
        if (lat != 16) begin
            n_fail++; $display("FAIL %s latency: got %0d want 16", name, lat);
        end
        n_tests++;
        if (o_bcd !== exp_b || o_ovf !== exp_o || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result(bin=%0d): got bcd=%h ovf=%b busy=%b want bcd=%h ovf=%b busy=0",
                     name, v, o_bcd, o_ovf, o_busy, exp_b, exp_o);
        end
        n_tests++;
        if (!held) begin
            n_fail++; $display("FAIL %s bcd_hold: got changed mid-run want %h held", name, prev);
        end
        tick;
        n_tests++;
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL %s done_width: got done=%b want 0", name, o_done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; set_in(0, 1'b1, 8'd99); set_in(1, 1'b1, 8'd99);
        repeat (3) tick;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b want 0 0 000 0",
                     busy, done, bcd, overflow);
        end
        rst_n = 1'b1; set_in(0, 1'b0, 8'd0); set_in(1, 1'b0, 8'd0);
        tick;
        n_tests++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_start: got busy=%b busy2=%b want 0 0", busy, busy2);
        end
    endtask

    task automatic test_sweep;
        int vals[6] = '{0, 9, 10, 99, 100, 255};
        int order[256];
        foreach (vals[i]) run_conv(0, vals[i], "sweep");
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) run_conv(0, order[i], "all_inputs");
    endtask

    task automatic test_handshake;
        int ndone = 0, t_done = -1;
        logic [11:0] got = '0;
        cur_sel = 0;
        set_in(0, 1'b1, 8'd123);
        tick;
        set_in(0, 1'b0, 8'($urandom));
        for (int t = 1; t <= 40; t++) begin
            if (t == 5) set_in(0, 1'b1, 8'd77);
            if (t == 6) set_in(0, 1'b0, 8'($urandom));
            tick;
            if (done === 1'b1) begin
                ndone++;
                if (t_done < 0) begin t_done = t; got = bcd; end
            end
        end
        n_tests++;
        if (ndone != 1 || t_done != 16 || got !== 12'h123) begin
            n_fail++;
            $display("FAIL handshake: got pulses=%0d at=%0d bcd=%h want 1 at 16 bcd=123",
                     ndone, t_done, got);
        end
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        int t_d[2] = '{-1, -1};
        logic [11:0] b_d[2] = '{12'h0, 12'h0};
        cur_sel = 0;
        set_in(0, 1'b1, 8'd37);
        tick;
        set_in(0, 1'b1, 8'd200);
        for (int t = 1; t <= 50; t++) begin
            tick;
            if (t == 17) set_in(0, 1'b0, 8'd0);
            if (done === 1'b1) begin
                if (ndone < 2) begin t_d[ndone] = t; b_d[ndone] = bcd; end
                ndone++;
            end
        end
        n_tests++;
        if (ndone != 2 || t_d[0] != 16 || t_d[1] != 33) begin
            n_fail++;
            $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d want 2 at 16,33",
                     ndone, t_d[0], t_d[1]);
        end
        n_tests++;
        if (b_d[0] !== 12'h037 || b_d[1] !== 12'h200) begin
            n_fail++;
            $display("FAIL b2b_values: got %h,%h want 037,200", b_d[0], b_d[1]);
        end
    endtask

    task automatic test_overflow;
        run_conv(1, 255, "ovf2_255");
        run_conv(1, 99, "ovf2_99");
        run_conv(1, 100, "ovf2_100");
        for (int i = 0; i < 24; i++) run_conv(1, int'($urandom_range(255, 0)), "ovf2_rand");
        cur_sel = 0;
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        cur_sel = 0;
        set_in(0, 1'b1, 8'd200);
        tick;
        set_in(0, 1'b0, 8'd200);
        repeat (6) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b bcd=%h ovf=%b want 0 0 000 0",
                     busy, done, bcd, overflow);
        end
        repeat (30) begin
            tick;
            if (done === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", ndone);
        end
        run_conv(0, 42, "post_reset");
    endtask

    initial begin
        start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0; rst_n = 1'b0;
        test_reset;
        test_sweep;
        test_handshake;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
